onehot_rr_arbiter: RTL and testbench
====================================

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 8, SHALL be the number of requesters (legal range 2..32).
REQ-002: Parameter MAX_HOLD, default 15, SHALL be the maximum consecutive cycles one grant is held (legal range >= 1).
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: resetn  input  1  SHALL be a synchronous, active-low reset.
REQ-005: req  input  NUM_REQ  SHALL carry the per-requester request level; bit i is requester i.
REQ-006: done  input  1  SHALL be a single-cycle pulse from the current owner releasing the resource.
REQ-007: gnt  output  NUM_REQ  SHALL be the registered grant vector; it is always one-hot or zero.
REQ-008: gnt_id  output  $clog2(NUM_REQ)  SHALL be the binary index of the set gnt bit, or 0 when gnt is zero.
REQ-009: busy  output  1  SHALL be high exactly when gnt is non-zero.
REQ-010: err  output  1  SHALL be the sticky grant-integrity error flag (see Configuration).

Function
REQ-011: The FSM SHALL have two states: IDLE (gnt zero) and GRANT (exactly one gnt bit set).
REQ-012: In IDLE with req non-zero, the next edge SHALL enter GRANT and grant the first set req bit at or after index ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-013: In IDLE with req zero, the FSM SHALL stay in IDLE and ptr SHALL be unchanged.
REQ-014: Grant latency SHALL be exactly one cycle from a sampled req in IDLE to gnt asserted.
REQ-015: On entering GRANT, a hold counter SHALL load 1 and increment once per cycle held, saturating at MAX_HOLD; width $clog2(MAX_HOLD+1).
REQ-016: In GRANT, release SHALL occur when any of: done=1, req[owner]=0, or hold counter == MAX_HOLD.
REQ-017: Multiple simultaneous release causes SHALL produce one release, identical to a single cause.
REQ-018: On release, the next edge SHALL return to IDLE (gnt zero for at least one cycle) and set ptr = owner+1 modulo NUM_REQ.
REQ-019: While in GRANT, req changes on non-owner bits SHALL be ignored; no preemption except by REQ-016.
REQ-020: A sole persistent requester SHALL be regranted after the one idle cycle; its grant is never longer than MAX_HOLD cycles.
REQ-021: done while in IDLE SHALL be ignored.

Reset
REQ-022: With resetn=0 at a rising edge, gnt=0, gnt_id=0, busy=0, err=0, ptr=0, hold counter=0, state=IDLE on that edge, regardless of req/done or current state (including mid-grant).
REQ-023: The first grant after reset deassertion SHALL follow REQ-012 with ptr=0.

Configuration
REQ-024: Macro ONEHOT_CHECK_EN, when defined, SHALL compile in a checker setting err (sticky until reset) the cycle after gnt has more than one bit set, or busy disagrees with (gnt != 0).
REQ-025: Without ONEHOT_CHECK_EN, err SHALL be tied to 0 and no checker logic SHALL be present; all other behaviour identical.

Verification (NUM_REQ=4, MAX_HOLD=3)
REQ-026: resetn=0 for 2 cycles with req=4'b1111, done=1 -> gnt=4'b0000, gnt_id=0, busy=0, err=0 throughout.
REQ-027: From reset, req=4'b0101 -> next cycle gnt=4'b0001, gnt_id=0; done pulse -> next cycle gnt=0; following cycle gnt=4'b0100, gnt_id=2.
REQ-028: req=4'b1111 held, done pulsed each grant cycle -> grant sequence 0001,0010,0100,1000,0001, each separated by one gnt=0 cycle.
REQ-029: req=4'b0010 held, done=0 -> gnt=4'b0010 for exactly 3 cycles, gnt=0 for 1 cycle, then gnt=4'b0010 again.
REQ-030: resetn=0 for one edge while gnt=4'b0100 -> gnt=0 on that edge; with req=4'b1111 afterward, first grant is 4'b0001.
REQ-031: With ONEHOT_CHECK_EN defined, 1000 cycles of random req/done -> err stays 0, gnt always one-hot or zero, busy == (gnt != 0).

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter with a registered one-hot grant, release on done/drop/hold limit.
// Define ONEHOT_CHECK_EN to build in the sticky grant-integrity checker that drives err.
module onehot_rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int MAX_HOLD = 15,
  localparam int IW = $clog2(NUM_REQ),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_id,
  output logic               busy,
  output logic               err
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic [HW-1:0] hold;
  logic rel;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      pick = req[IW'((int'(ptr) + k) % NUM_REQ)] ? IW'((int'(ptr) + k) % NUM_REQ) : pick;
    rel = done | ~req[gnt_id] | (hold == HW'(MAX_HOLD));
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      busy <= 1'b0;
      ptr <= '0;
      hold <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= GRANT;
        gnt <= ONE << pick;
        gnt_id <= pick;
        busy <= 1'b1;
        hold <= HW'(1);
      end
    end else if (rel) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      busy <= 1'b0;
      hold <= '0;
      ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else begin
      hold <= (hold == HW'(MAX_HOLD)) ? hold : hold + 1'b1;
    end
  end
`ifdef ONEHOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!resetn) err <= 1'b0;
    else err <= err | ((gnt & (gnt - 1'b1)) != '0) | (busy != (gnt != '0));
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed scenarios plus random req/done against an integer-level arbitration model.
module tb_onehot_rr_arbiter;
  localparam int N = 4;
  localparam int MH = 3;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [N-1:0] req = '0;
  logic done = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0] gnt_id;
  logic busy, err;
  int checks = 0;
  int errors = 0;
  int owner = -1;
  int mptr = 0;
  int held = 0;
  onehot_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    if (!resetn) begin
      owner = -1;
      mptr = 0;
      held = 0;
    end else if (owner < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(mptr + k) % N]) owner = (mptr + k) % N;
      held = (owner >= 0) ? 1 : 0;
    end else if (done || !req[owner] || held == MH) begin
      mptr = (owner + 1) % N;
      owner = -1;
      held = 0;
    end else begin
      held++;
    end
  endtask
  task automatic cyc(input logic rn, input logic [N-1:0] r, input logic d);
    logic [N-1:0] eg;
    resetn = rn;
    req = r;
    done = d;
    @(posedge clk);
    model_edge();
    #1;
    eg = (owner < 0) ? '0 : N'(1) << owner;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_id", 32'(gnt_id), (owner < 0) ? 0 : owner);
    check("busy", 32'(busy), 32'(owner >= 0));
    check("err", 32'(err), 0);
    check("onehot", 32'((gnt & (gnt - 1'b1)) != '0), 0);
  endtask
  initial begin
    logic [N-1:0] seq [4];
    logic [N-1:0] hold_seq [5];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    hold_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
    cyc(1'b0, 4'b1111, 1'b1);
    check("rst_gnt", 32'(gnt), 0);
    cyc(1'b0, 4'b1111, 1'b1);
    check("rst_busy", 32'(busy), 0);
    cyc(1'b1, 4'b0101, 1'b0);
    check("first_gnt", 32'(gnt), 32'h1);
    cyc(1'b1, 4'b0101, 1'b1);
    check("done_rel", 32'(gnt), 0);
    cyc(1'b1, 4'b0101, 1'b0);
    check("rr_gnt", 32'(gnt), 32'h4);
    check("rr_id", 32'(gnt_id), 2);
    cyc(1'b0, 4'b1111, 1'b0);
    check("midrst", 32'(gnt), 0);
    cyc(1'b1, 4'b1111, 1'b0);
    check("post_rst", 32'(gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'b1111, 1'b1);
      check("rot_gap", 32'(gnt), 0);
      cyc(1'b1, 4'b1111, 1'b0);
      check("rot", 32'(gnt), 32'(seq[i]));
    end
    cyc(1'b1, 4'b0010, 1'b0);
    check("drop_rel", 32'(gnt), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 4'b0010, 1'b0);
      check("maxhold", 32'(gnt), 32'(hold_seq[i]));
    end
    for (int i = 0; i < 1000; i++)
      cyc(($urandom_range(0, 49) != 0), N'($urandom), ($urandom_range(0, 3) == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
